// File: rtl/hilo_pkg.sv
// hilo_pkg: op codes and default sizes for the HI/LO register unit
package hilo_pkg;
    localparam int HILO_OPW   = 3;
    localparam int HILO_WIDTH = 32;
    localparam logic [HILO_OPW-1:0] HILO_NOP     = 3'b000;
    localparam logic [HILO_OPW-1:0] HILO_WHI     = 3'b001;
    localparam logic [HILO_OPW-1:0] HILO_WLO     = 3'b010;
    localparam logic [HILO_OPW-1:0] HILO_WBOTH   = 3'b011;
    localparam logic [HILO_OPW-1:0] HILO_ACC_ADD = 3'b100;
    localparam logic [HILO_OPW-1:0] HILO_ACC_SUB = 3'b101;
endpackage

// File: rtl/hilo_addsub.sv
// hilo_addsub: combinational double-width add/subtract, carry out of the top discarded
module hilo_addsub #(
    parameter int W2 = 64
) (
    input  logic [W2-1:0] a,
    input  logic [W2-1:0] b,
    input  logic          sub,
    output logic [W2-1:0] y
);
    assign y = sub ? a - b : a + b;
endmodule

// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO special registers with a two-stage issue/commit pipeline and flush
module hilo_acc
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [HILO_OPW-1:0] op_i,
    input  logic [WIDTH-1:0]    hi_i,
    input  logic [WIDTH-1:0]    lo_i,
    input  logic                flush_i,
    output logic [WIDTH-1:0]    hi_o,
    output logic [WIDTH-1:0]    lo_o,
    output logic                pending_o
);
    logic                s1_valid;
    logic [HILO_OPW-1:0] s1_op;
    logic [WIDTH-1:0]    s1_hi, s1_lo;
    logic                accept, commit, wr_hi, wr_lo, is_acc;
    logic [2*WIDTH-1:0]  acc_y;
    logic [WIDTH-1:0]    nxt_hi, nxt_lo;
    // codes 110/111 behave as NOP and never occupy stage 1
    assign accept = valid_i && !flush_i && op_i inside {HILO_WHI, HILO_WLO, HILO_WBOTH, HILO_ACC_ADD, HILO_ACC_SUB};
    assign commit = s1_valid && !flush_i;
    assign pending_o = s1_valid;
    assign wr_hi  = s1_op == HILO_WHI || s1_op == HILO_WBOTH;
    assign wr_lo  = s1_op == HILO_WLO || s1_op == HILO_WBOTH;
    assign is_acc = s1_op == HILO_ACC_ADD || s1_op == HILO_ACC_SUB;
    hilo_addsub #(.W2(2*WIDTH)) u_addsub (
        .a   ({hi_o, lo_o}),
        .b   ({s1_hi, s1_lo}),
        .sub (s1_op == HILO_ACC_SUB),
        .y   (acc_y)
    );
    always_comb begin
        nxt_hi = wr_hi ? s1_hi : is_acc ? acc_y[2*WIDTH-1:WIDTH] : hi_o;
        nxt_lo = wr_lo ? s1_lo : is_acc ? acc_y[WIDTH-1:0] : lo_o;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            s1_valid <= accept;
            if (commit) begin
                hi_o <= nxt_hi;
                lo_o <= nxt_lo;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op <= op_i;
            s1_hi <= hi_i;
            s1_lo <= lo_i;
        end
    end
endmodule

// File: tb/tb_hilo_acc.sv
// tb_hilo_acc: directed test plan plus random ops against a 64-bit arithmetic reference model
module tb_hilo_acc;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] hi_i = '0, lo_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] hi_o, lo_o;
    logic        pending_o;
    int checks = 0;
    int failures = 0;
    logic [63:0] m_acc = '0;
    bit          m_pv = 1'b0;
    logic [2:0]  m_op = '0;
    logic [63:0] m_opnd = '0;

    hilo_acc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .hi_i(hi_i),
        .lo_i(lo_i), .flush_i(flush_i), .hi_o(hi_o), .lo_o(lo_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs, advance model at the edge, compare #1 later
    task automatic step(input bit r, input bit v, input logic [2:0] op,
                        input logic [31:0] h, input logic [31:0] l, input bit f);
        reset = r; valid_i = v; op_i = op; hi_i = h; lo_i = l; flush_i = f;
        @(posedge clk);
        if (!r) begin
            m_acc = '0;
            m_pv = 1'b0;
        end else begin
            if (m_pv && !f) begin
                case (m_op)
                    3'd1: m_acc[63:32] = m_opnd[63:32];
                    3'd2: m_acc[31:0] = m_opnd[31:0];
                    3'd3: m_acc = m_opnd;
                    3'd4: m_acc = m_acc + m_opnd;
                    3'd5: m_acc = m_acc - m_opnd;
                    default: ;
                endcase
            end
            m_pv = v && !f && op >= 3'd1 && op <= 3'd5;
            m_op = op;
            m_opnd = {h, l};
        end
        #1;
        chk("model_hi", hi_o, m_acc[63:32]);
        chk("model_lo", lo_o, m_acc[31:0]);
        chk("model_pend", pending_o, m_pv);
    endtask

    task automatic nop();
        step(1, 0, 3'd0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        nop();
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_pend", pending_o, 0);
        step(1, 1, 3'd3, 32'hDEADBEEF, 32'hCAFEF00D, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_mid_hi", hi_o, 0);
        chk("rst_mid_pend", pending_o, 0);
        nop();
        chk("rst_mid_lo", lo_o, 0);

        step(1, 1, 3'd3, 32'h12345678, 32'h9ABCDEF0, 0);
        chk("wboth_pend", pending_o, 1);
        step(1, 1, 3'd1, 32'hAAAAAAAA, 32'h11111111, 0);
        chk("wboth_hi", hi_o, 32'h12345678);
        chk("wboth_lo", lo_o, 32'h9ABCDEF0);
        step(1, 1, 3'd2, 32'h22222222, 32'h55555555, 0);
        chk("whi_hi", hi_o, 32'hAAAAAAAA);
        chk("whi_lo", lo_o, 32'h9ABCDEF0);
        nop();
        chk("wlo_lo", lo_o, 32'h55555555);
        chk("wlo_hi", hi_o, 32'hAAAAAAAA);
        chk("idle_pend", pending_o, 0);

        step(1, 1, 3'd3, 32'h0, 32'hFFFFFFFF, 0);
        step(1, 1, 3'd4, 32'h0, 32'h1, 0);
        nop();
        chk("carry", {hi_o, lo_o}, 64'h00000001_00000000);

        step(1, 1, 3'd3, 0, 0, 0);
        step(1, 1, 3'd5, 0, 1, 0);
        step(1, 1, 3'd4, 0, 1, 0);
        chk("borrow", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
        step(1, 1, 3'd4, 0, 1, 0);
        chk("b2b0", {hi_o, lo_o}, 64'h0);
        step(1, 1, 3'd4, 0, 1, 0);
        chk("b2b1", {hi_o, lo_o}, 64'h1);
        nop();
        chk("b2b2", {hi_o, lo_o}, 64'h2);

        step(1, 1, 3'd3, 0, 7, 0);
        nop();
        step(1, 1, 3'd2, 0, 5, 0);
        step(1, 1, 3'd2, 0, 9, 1);
        chk("flush_lo", lo_o, 7);
        chk("flush_pend", pending_o, 0);
        nop();
        chk("flush_after", lo_o, 7);

        step(1, 1, 3'd6, 1, 1, 0);
        chk("op6_pend", pending_o, 0);
        step(1, 1, 3'd7, 1, 1, 0);
        chk("op7_pend", pending_o, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
                 ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
